// File: rtl/pulse_stretch_if.sv
// Trigger/pulse bundle for pulse_stretch.
// Handshake: there is no valid/ready pair. trig is a strobe sampled on every
// rising clk edge. len and retrig_en are only read on an edge where trig=1.
// pulse_out/busy/done/drop are registered, so they are stable for the whole cycle.
interface pulse_stretch_if #(
    parameter int CNT_W = 8
);
    logic             trig;
    logic [CNT_W-1:0] len;
    logic             retrig_en;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             drop;
    logic [1:0]       dbg_state;

    modport master (
        output trig, len, retrig_en,
        input  pulse_out, busy, done, drop, dbg_state
    );

    modport slave (
        input  trig, len, retrig_en,
        output pulse_out, busy, done, drop, dbg_state
    );
endinterface

// File: rtl/pulse_stretch.sv
// Counter-based pulse stretcher: each accepted trigger drives pulse_out high
// for exactly len cycles, followed by MIN_GAP forced-low cycles.
module pulse_stretch #(
    parameter int CNT_W   = 8,
    parameter int MIN_GAP = 1
) (
    input  logic           clk,
    input  logic           rst,
    pulse_stretch_if.slave bus
);
    // The counter must hold both a length reload and a gap reload.
    localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int CW     = (CNT_W > GAP_W) ? CNT_W : GAP_W;
    localparam int GAP_LD = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_LD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] len_ld;
    logic          start_ok;

    // A trigger can only start or reload a pulse when it asks for a non-zero length.
    assign start_ok = bus.trig && (bus.len != '0);
    // The counter runs from len-1 down to 0, so len cycles are spent in HIGH.
    assign len_ld   = CW'(bus.len) - CW'(1);

    // State, counter and strobe registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    // Next-state, counter and strobe decisions for the current cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_HIGH;
                    cnt_d   = len_ld;
                end else if (bus.trig) begin
                    drop_d = 1'b1;
                end
            end
            S_HIGH: begin
                // A reload wins over the end-of-count, so a retrigger on the
                // last high cycle extends the pulse without a low cycle.
                if (start_ok && bus.retrig_en) begin
                    cnt_d = len_ld;
                end else begin
                    drop_d = bus.trig;
                    if (cnt == '0) begin
                        done_d = 1'b1;
                        if (MIN_GAP > 0) begin
                            state_d = S_GAP;
                            cnt_d   = GAP_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
            end
            S_GAP: begin
                // The edge that closes the gap may already accept a trigger:
                // the low time is then exactly MIN_GAP cycles.
                if (cnt == '0) begin
                    if (start_ok) begin
                        state_d = S_HIGH;
                        cnt_d   = len_ld;
                    end else begin
                        state_d = S_IDLE;
                        drop_d  = bus.trig;
                    end
                end else begin
                    cnt_d  = cnt - CW'(1);
                    drop_d = bus.trig;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.pulse_out = (state == S_HIGH);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.drop      = drop_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: three instances (MIN_GAP 0, 2, 3) share one
// stimulus stream; a remaining-cycles model predicts every output each cycle.
module tb_pulse_stretch;
    localparam int CNT_W = 8;
    localparam int N     = 3;

    function automatic int mg_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    logic             clk;
    logic             rst;
    logic             trig_r;
    logic             rt_r;
    logic [CNT_W-1:0] len_r;

    logic po [N];
    logic bz [N];
    logic dn [N];
    logic dr [N];
    logic [1:0] dbg [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            pulse_stretch_if #(.CNT_W(CNT_W)) bus ();
            assign bus.trig      = trig_r;
            assign bus.len       = len_r;
            assign bus.retrig_en = rt_r;
            assign po[g]  = bus.pulse_out;
            assign bz[g]  = bus.busy;
            assign dn[g]  = bus.done;
            assign dr[g]  = bus.drop;
            assign dbg[g] = bus.dbg_state;
            pulse_stretch #(.CNT_W(CNT_W), .MIN_GAP(mg_of(g))) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hi_rem: high cycles still to come; gap_rem: forced-low cycles still to come.
    int m_hi  [N];
    int m_gap [N];
    bit m_dn  [N];
    bit m_dr  [N];

    function automatic void step(input int mg, input int hr, input int gr,
                                 input bit t, input bit rt, input int l,
                                 output int nhr, output int ngr,
                                 output bit ndn, output bit ndr);
        nhr = hr; ngr = gr; ndn = 1'b0; ndr = 1'b0;
        if (hr > 0) begin
            if (t && rt && l != 0) begin
                nhr = l;
            end else begin
                ndr = t;
                nhr = hr - 1;
                if (nhr == 0) begin
                    ndn = 1'b1;
                    ngr = mg;
                end
            end
        end else begin
            if (gr > 0) ngr = gr - 1;
            if (t) begin
                if (ngr == 0 && l != 0) nhr = l;
                else ndr = 1'b1;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        int nhr, ngr;
        bit ndn, ndr;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_hi[i]  <= 0;
                m_gap[i] <= 0;
                m_dn[i]  <= 1'b0;
                m_dr[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                step(mg_of(i), m_hi[i], m_gap[i], trig_r, rt_r, int'(len_r),
                     nhr, ngr, ndn, ndr);
                m_hi[i]  <= nhr;
                m_gap[i] <= ngr;
                m_dn[i]  <= ndn;
                m_dr[i]  <= ndr;
            end
        end
    end

    // ---------------- scoreboard / stats ----------------
    int checks   = 0;
    int failures = 0;
    int hi_c [N];
    int bz_c [N];
    int dn_c [N];
    int dr_c [N];
    int ri_c [N];
    bit prev_po [N];
    int s_hi [N];
    int s_bz [N];
    int s_dn [N];
    int s_dr [N];
    int s_ri [N];

    task automatic chk(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, inst, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk("pulse_out", i, int'(po[i]), int'(m_hi[i] > 0));
            chk("busy", i, int'(bz[i]), int'(m_hi[i] > 0 || m_gap[i] > 0));
            chk("done", i, int'(dn[i]), int'(m_dn[i]));
            chk("drop", i, int'(dr[i]), int'(m_dr[i]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        for (int i = 0; i < N; i++) begin
            if (po[i] === 1'b1) hi_c[i]++;
            if (bz[i] === 1'b1) bz_c[i]++;
            if (dn[i] === 1'b1) dn_c[i]++;
            if (dr[i] === 1'b1) dr_c[i]++;
            if (po[i] === 1'b1 && !prev_po[i]) ri_c[i]++;
            prev_po[i] = (po[i] === 1'b1);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            s_hi[i] = hi_c[i]; s_bz[i] = bz_c[i]; s_dn[i] = dn_c[i];
            s_dr[i] = dr_c[i]; s_ri[i] = ri_c[i];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit t, input int l, input bit rt);
        trig_r = t;
        len_r  = CNT_W'(l);
        rt_r   = rt;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, int'(len_r), rt_r);
    endtask

    // trig on the listed tick offsets within a window of n ticks
    task automatic trig_at(input int l, input bit rt, input int a, input int b,
                           input int c, input int d, input int n);
        for (int k = 0; k < n; k++)
            drive((k == a) || (k == b) || (k == c) || (k == d), l, rt);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            hi_c[i] = 0; bz_c[i] = 0; dn_c[i] = 0; dr_c[i] = 0; ri_c[i] = 0;
            prev_po[i] = 1'b0;
        end
        rst = 1'b1; trig_r = 1'b0; len_r = '0; rt_r = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            chk("rst_pulse", i, int'(po[i]), 0);
            chk("rst_busy", i, int'(bz[i]), 0);
        end
        rst = 1'b0;

        // single trigger, len=5
        snap();
        trig_at(5, 1'b0, 0, -1, -1, -1, 14);
        chk("p1_high", 1, hi_c[1] - s_hi[1], 5);
        chk("p1_busy", 1, bz_c[1] - s_bz[1], 7);
        chk("p1_done", 1, dn_c[1] - s_dn[1], 1);
        chk("p1_drop", 1, dr_c[1] - s_dr[1], 0);

        // retrigger enabled, len=4: reload at 2, at 3 (last high), at 4 (cnt=0)
        snap();
        trig_at(4, 1'b1, 0, 2, -1, -1, 14);
        chk("rt2_high", 1, hi_c[1] - s_hi[1], 6);
        chk("rt2_rise", 1, ri_c[1] - s_ri[1], 1);
        chk("rt2_done", 1, dn_c[1] - s_dn[1], 1);
        snap();
        trig_at(4, 1'b1, 0, 3, -1, -1, 14);
        chk("rt3_high", 1, hi_c[1] - s_hi[1], 7);
        chk("rt3_done", 1, dn_c[1] - s_dn[1], 1);
        snap();
        trig_at(4, 1'b1, 0, 4, -1, -1, 14);
        chk("rt4_high", 0, hi_c[0] - s_hi[0], 8);
        chk("rt4_rise", 0, ri_c[0] - s_ri[0], 1);
        chk("rt4_done", 0, dn_c[0] - s_dn[0], 1);

        // retrigger disabled with gap 3: trig at 0,2,5,7
        snap();
        trig_at(4, 1'b0, 0, 2, 5, 7, 18);
        chk("gap_high", 2, hi_c[2] - s_hi[2], 8);
        chk("gap_rise", 2, ri_c[2] - s_ri[2], 2);
        chk("gap_drop", 2, dr_c[2] - s_dr[2], 2);
        chk("gap_done", 2, dn_c[2] - s_dn[2], 2);
        chk("gap_busy", 2, bz_c[2] - s_bz[2], 14);

        // len=0 in IDLE
        snap();
        trig_at(0, 1'b0, 0, -1, -1, -1, 4);
        chk("len0_high", 1, hi_c[1] - s_hi[1], 0);
        chk("len0_drop", 1, dr_c[1] - s_dr[1], 1);

        // len=1
        snap();
        trig_at(1, 1'b0, 0, -1, -1, -1, 6);
        chk("len1_high", 1, hi_c[1] - s_hi[1], 1);
        chk("len1_busy", 1, bz_c[1] - s_bz[1], 3);
        chk("len1_done", 1, dn_c[1] - s_dn[1], 1);

        // len=255
        snap();
        trig_at(255, 1'b0, 0, -1, -1, -1, 262);
        chk("len255_high", 0, hi_c[0] - s_hi[0], 255);
        chk("len255_done", 0, dn_c[0] - s_dn[0], 1);

        // MIN_GAP=0, trig held high, no retrigger: 3 high / 1 low
        snap();
        for (int k = 0; k < 16; k++) drive(1'b1, 3, 1'b0);
        chk("hold_high", 0, hi_c[0] - s_hi[0], 12);
        chk("hold_rise", 0, ri_c[0] - s_ri[0], 4);
        chk("hold_done", 0, dn_c[0] - s_dn[0], 4);
        chk("hold_drop", 0, dr_c[0] - s_dr[0], 12);
        idle(10);

        // async reset mid-pulse, len=10
        snap();
        trig_at(10, 1'b0, 0, -1, -1, -1, 4);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("arst_pulse", i, int'(po[i]), 0);
            chk("arst_busy", i, int'(bz[i]), 0);
        end
        tick();
        rst = 1'b0;
        idle(5);
        chk("arst_done", 1, dn_c[1] - s_dn[1], 0);
        snap();
        trig_at(10, 1'b0, 0, -1, -1, -1, 15);
        chk("post_rst_high", 1, hi_c[1] - s_hi[1], 10);
        chk("post_rst_done", 1, dn_c[1] - s_dn[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
